// File: rtl/riscv_bus.sv
// riscv_bus: arbitrates one word-addressed memory port between instruction
// fetch and data load/store. Sub-word stores use read-modify-write.
//
// Handshake: a memory strobe (memory_read / memory_write) is raised with its
// address and data, and all of them stay stable until the matching ready input
// is sampled high on a rising clock edge; that edge is the transfer. Read data
// (memory_in, tagged by memory_address_requested) is valid in the cycle that
// follows the accepted read.
module riscv_bus (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] memory_read_address,
  output logic [31:0] memory_write_address,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] memory_out,
  input  logic [31:0] memory_in,
  input  logic        memory_read_ready,
  input  logic        memory_write_ready,
  input  logic [31:0] memory_address_requested,
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction_value,
  output logic        instruction_ready,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_WAIT = 3'd1,
    LOAD_WAIT  = 3'd2,
    RMW_WAIT   = 3'd3,
    WRITE      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] fetch_address;   // instruction_address captured when the fetch was issued
  logic [31:0] merged_word;     // read-modify-write result held for the WRITE state
  logic        write_ack;       // the transition into DONE came from an accepted write

  logic [31:0] data_word_address;
  logic [31:0] fetch_word_address;
  logic [4:0]  byte_shift;
  logic [31:0] width_mask;
  logic [31:0] lane_mask;
  logic [31:0] load_value;
  logic [31:0] merged_value;
  logic        is_word;
  logic        fetch_issue;
  logic        write_accept;

  // Address alignment and byte-lane helpers; lanes shifted past bit 31 fall off,
  // which confines sub-word accesses to the addressed word.
  always_comb begin
    data_word_address  = {data_address[31:2], 2'b00};
    fetch_word_address = {instruction_address[31:2], 2'b00};
    byte_shift         = {data_address[1:0], 3'b000};
    is_word            = data_width[1];
    case (data_width)
      2'd0:    width_mask = 32'h0000_00ff;
      2'd1:    width_mask = 32'h0000_ffff;
      default: width_mask = 32'hffff_ffff;
    endcase
    lane_mask    = width_mask << byte_shift;
    load_value   = (memory_in >> byte_shift) & width_mask;
    merged_value = (memory_in & ~lane_mask) | ((data_in << byte_shift) & lane_mask);
  end

  assign fetch_issue  = (state == IDLE) && !data_read && !data_write;
  assign write_accept = memory_write && memory_write_ready;
  assign debug_state  = state;

  // State register plus the few datapath registers that outlive one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      fetch_address <= 32'h0;
      merged_word   <= 32'h0;
      write_ack     <= 1'b0;
    end else begin
      state     <= next_state;
      write_ack <= write_accept;
      if (fetch_issue) begin
        fetch_address <= instruction_address;
      end
      if (state == RMW_WAIT) begin
        merged_word <= merged_value;
      end
    end
  end

  // Next-state: data requests win in IDLE, writes win over reads.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (data_write) begin
          if (is_word) begin
            if (memory_write_ready) next_state = DONE;
          end else begin
            if (memory_read_ready) next_state = RMW_WAIT;
          end
        end else if (data_read) begin
          if (memory_read_ready) next_state = LOAD_WAIT;
        end else begin
          if (memory_read_ready) next_state = FETCH_WAIT;
        end
      end
      FETCH_WAIT: next_state = IDLE;
      LOAD_WAIT:  next_state = DONE;
      RMW_WAIT:   next_state = WRITE;
      WRITE:      if (memory_write_ready) next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Outputs: everything is forced low while reset is high so an aborted
  // transaction cannot leak a strobe.
  always_comb begin
    memory_read_address  = 32'h0;
    memory_write_address = 32'h0;
    memory_read          = 1'b0;
    memory_write         = 1'b0;
    memory_out           = 32'h0;
    instruction_value    = 32'h0;
    instruction_ready    = 1'b0;
    data_out             = 32'h0;
    data_ready           = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (data_write) begin
            if (is_word) begin
              memory_write         = 1'b1;
              memory_write_address = data_word_address;
              memory_out           = data_in;
            end else begin
              memory_read          = 1'b1;
              memory_read_address  = data_word_address;
            end
          end else if (data_read) begin
            memory_read         = 1'b1;
            memory_read_address = data_word_address;
          end else begin
            memory_read         = 1'b1;
            memory_read_address = fetch_word_address;
          end
        end
        FETCH_WAIT: begin
          instruction_value = memory_in;
          // Only report the word if it is the one we asked for and the core
          // still wants it; otherwise IDLE refetches.
          instruction_ready = (memory_address_requested == {fetch_address[31:2], 2'b00}) &&
                              (instruction_address == fetch_address);
        end
        LOAD_WAIT: begin
          data_out   = load_value;
          data_ready = 1'b1;
        end
        WRITE: begin
          memory_write         = 1'b1;
          memory_write_address = data_word_address;
          memory_out           = merged_word;
        end
        DONE: begin
          // Stores complete here; loads already signalled in LOAD_WAIT.
          data_ready = write_ack;
        end
        default: begin
          memory_read = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_bus.sv
// Bench for riscv_bus: word-array memory, byte-level reference model, directed
// load/store/fetch/reset scenarios.
module tb_riscv_bus;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] memory_read_address;
  logic [31:0] memory_write_address;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] memory_out;
  logic [31:0] memory_in = 32'h0;
  logic        memory_read_ready = 1'b1;
  logic        memory_write_ready = 1'b1;
  logic [31:0] memory_address_requested = 32'h0;
  logic [31:0] instruction_address = 32'h0;
  logic [31:0] instruction_value;
  logic        instruction_ready;
  logic [31:0] data_address = 32'h0;
  logic [1:0]  data_width = 2'd0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_ready;
  logic [2:0]  debug_state;

  riscv_bus dut (
    .clock(clock), .reset(reset),
    .memory_read_address(memory_read_address), .memory_write_address(memory_write_address),
    .memory_read(memory_read), .memory_write(memory_write), .memory_out(memory_out),
    .memory_in(memory_in), .memory_read_ready(memory_read_ready),
    .memory_write_ready(memory_write_ready), .memory_address_requested(memory_address_requested),
    .instruction_address(instruction_address), .instruction_value(instruction_value),
    .instruction_ready(instruction_ready), .data_address(data_address), .data_width(data_width),
    .data_read(data_read), .data_write(data_write), .data_in(data_in),
    .data_out(data_out), .data_ready(data_ready), .debug_state(debug_state)
  );

  // ---------------- bookkeeping ----------------
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          write_count = 0;
  int          ready_pulses = 0;
  int          fetch_hits = 0;
  logic        rd_accepted = 1'b0;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] read_log [$];
  logic [31:0] exp_q [$];
  logic [31:0] cur_addr = 32'h0;
  logic [1:0]  cur_width = 2'd0;
  logic [31:0] cur_data = 32'h0;
  bit          cur_store = 1'b0;
  bit          busy = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0)        return 32'h0000_0013;
    else if (i == 1)   return 32'h0010_0093;
    else if (i == 64)  return 32'hdead_beef;
    else if (i == 128) return 32'h1122_3344;
    else if (i == 192) return 32'h0;
    else               return 32'(i) ^ 32'ha5a5_0000;
  endfunction

  // Reference load: gather the requested bytes one at a time; bytes past the
  // end of the word read as zero.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] width);
    logic [31:0] r;
    int n;
    r = 32'h0;
    n = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++)
      if (int'(off) + i < 4) r[8*i +: 8] = w[8*(int'(off)+i) +: 8];
    return r;
  endfunction

  // Reference store: overwrite the addressed bytes; bytes past the word are dropped.
  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] width, input logic [31:0] d);
    logic [31:0] r;
    int n;
    r = w;
    n = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++)
      if (int'(off) + i < 4) r[8*(int'(off)+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  always @(posedge clock) begin
    if (cyc == 0)
      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    cyc++;
    if (memory_read && memory_read_ready) begin
      memory_in <= mem[memory_read_address[11:2]];
      memory_address_requested <= memory_read_address;
      rd_accepted <= 1'b1;
      read_log.push_back(memory_read_address);
    end else begin
      rd_accepted <= 1'b0;
    end
    if (memory_write && memory_write_ready) begin
      mem[memory_write_address[11:2]] = memory_out;
      write_count++;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clock) begin
    if (reset) begin
      check("reset_strobes", {28'h0, memory_read, memory_write, data_ready, instruction_ready}, 32'h0);
      check("reset_values", data_out | instruction_value | memory_out, 32'h0);
    end else begin
      check("state_legal", {31'h0, debug_state < 3'd6}, 32'h1);
      check("strobe_exclusive", {31'h0, memory_read & memory_write}, 32'h0);
      if (data_ready) begin
        ready_pulses++;
        check("ready_while_busy", {31'h0, busy}, 32'h1);
        if (!cur_store) begin
          if (exp_q.size() == 0) check("load_unexpected", data_out, 32'hxxxx_xxxx);
          else check("load_data", data_out, exp_q.pop_front());
        end
      end
      if (instruction_ready) begin
        fetch_hits++;
        check("fetch_value", instruction_value, ref_mem[instruction_address[11:2]]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_access(input bit is_store, input bit rd, input logic [31:0] addr,
                              input logic [1:0] w, input logic [31:0] d);
    cur_addr = addr; cur_width = w; cur_store = is_store; cur_data = d; busy = 1'b1;
    data_address = addr; data_width = w; data_in = d;
    data_write = is_store; data_read = rd;
    if (!is_store) exp_q.push_back(model_load(ref_mem[addr[11:2]], addr[1:0], w));
  endtask

  task automatic finish_access(output logic [31:0] got, output int lat);
    int issue_cyc;
    bit done;
    issue_cyc = -100; done = 1'b0; got = 32'h0; lat = -1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clock);
      if (data_ready) begin
        got = data_out; lat = cyc - issue_cyc; done = 1'b1;
      end else if (memory_read && memory_read_ready &&
                   memory_read_address == {cur_addr[31:2], 2'b00}) begin
        issue_cyc = cyc;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout: no data_ready for address %h", cur_addr);
    end
    @(posedge clock); #2;
    data_read = 1'b0; data_write = 1'b0; busy = 1'b0;
    if (cur_store)
      ref_mem[cur_addr[11:2]] = model_store(ref_mem[cur_addr[11:2]], cur_addr[1:0], cur_width, cur_data);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] w,
                         output logic [31:0] got, output int lat);
    @(posedge clock); #2;
    start_access(1'b0, 1'b1, addr, w, 32'h0);
    finish_access(got, lat);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] d,
                          input bit both);
    logic [31:0] got;
    int lat;
    @(posedge clock); #2;
    start_access(1'b1, both, addr, w, d);
    finish_access(got, lat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] got;
    int lat, wc, rp, fh, mark;
    bit seen;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("first_fetch_strobe", {31'h0, memory_read}, 32'h1);
    check("first_fetch_addr", memory_read_address, 32'h0);

    // word load and its issue-to-ready latency
    do_load(32'h100, 2'd2, got, lat);
    check("word_load", got, 32'hdead_beef);
    check("word_load_latency", 32'(lat), 32'd1);
    do_load(32'h103, 2'd0, got, lat);
    check("byte_load_103", got, 32'h0000_00de);
    do_load(32'h102, 2'd1, got, lat);
    check("half_load_102", got, 32'h0000_dead);

    // byte store through read-modify-write
    wc = write_count; rp = ready_pulses;
    do_store(32'h201, 2'd0, 32'h0000_00ab, 1'b0);
    repeat (3) @(negedge clock);
    check("byte_store_word", mem[128], 32'h1122_ab44);
    check("byte_store_writes", 32'(write_count - wc), 32'd1);
    check("byte_store_ready", 32'(ready_pulses - rp), 32'd1);

    // half store and half load crossing the word boundary
    do_store(32'h203, 2'd1, 32'h0000_cdef, 1'b0);
    check("cross_store_word", mem[128], 32'hef22_ab44);
    do_load(32'h103, 2'd1, got, lat);
    check("cross_half_load", got, 32'h0000_00de);

    // word store held off by the memory for several cycles
    wc = write_count;
    memory_write_ready = 1'b0;
    @(posedge clock); #2;
    start_access(1'b1, 1'b0, 32'h300, 2'd2, 32'hcafe_f00d);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_strobe", {31'h0, memory_write}, 32'h1);
      check("stall_addr", memory_write_address, 32'h300);
      check("stall_data", memory_out, 32'hcafe_f00d);
    end
    @(posedge clock); #2 memory_write_ready = 1'b1;
    finish_access(got, lat);
    check("stall_store_word", mem[192], 32'hcafe_f00d);
    check("stall_store_writes", 32'(write_count - wc), 32'd1);

    // read and write together: the write is performed
    do_store(32'h304, 2'd2, 32'h1234_5678, 1'b1);
    check("rw_both_word", mem[193], 32'h1234_5678);
    do_load(32'h304, 2'd2, got, lat);
    check("rw_both_readback", got, 32'h1234_5678);

    // load requested in an idle cycle that would otherwise fetch
    instruction_address = 32'h0;
    repeat (4) @(posedge clock);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #2;
      if (!rd_accepted) break;
    end
    mark = read_log.size();
    start_access(1'b0, 1'b1, 32'h100, 2'd2, 32'h0);
    @(negedge clock);
    check("contention_first_addr", memory_read_address, 32'h100);
    finish_access(got, lat);
    if (read_log.size() > mark) check("contention_log", read_log[mark], 32'h100);
    else check("contention_log", 32'hffff_ffff, 32'h100);
    fh = fetch_hits;
    for (int k = 0; k < 10 && fetch_hits == fh; k++) @(negedge clock);
    check("fetch_after_load", {31'h0, fetch_hits > fh}, 32'h1);

    // fetch address changes while the fetch is in flight
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #2;
      if (rd_accepted && memory_address_requested == 32'h0) break;
    end
    instruction_address = 32'h4;
    @(negedge clock);
    check("stale_fetch_ready", {31'h0, instruction_ready}, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (instruction_ready) begin
        seen = 1'b1;
        check("refetch_value", instruction_value, 32'h0010_0093);
      end
    end
    check("refetch_seen", {31'h0, seen}, 32'h1);

    // reset while the read half of a byte store is outstanding
    wc = write_count;
    @(posedge clock); #2;
    start_access(1'b1, 1'b0, 32'h202, 2'd0, 32'h0000_0077);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #2;
      if (rd_accepted && memory_address_requested == 32'h200) break;
    end
    reset = 1'b1;
    @(negedge clock);
    check("abort_no_write_a", {31'h0, memory_write}, 32'h0);
    @(posedge clock); #2;
    data_write = 1'b0; busy = 1'b0;
    @(negedge clock);
    check("abort_no_write_b", {31'h0, memory_write}, 32'h0);
    @(posedge clock); #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_write_count", 32'(write_count - wc), 32'd0);
    check("abort_word_intact", mem[128], 32'hef22_ab44);
    do_load(32'h100, 2'd2, got, lat);
    check("load_after_reset", got, 32'hdead_beef);

    repeat (2) @(negedge clock);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
